// File: rtl/tp_snd_pkg.sv
// Shared types and constants for the AY channel low-pass filter scheduler.
// The filter state is Q16.8 and the coefficients are unsigned Q0.16.
package tp_snd_pkg;

  localparam int NCH  = 6;
  localparam int XW   = 16;
  localparam int FRAC = 8;
  localparam int YW   = XW + FRAC;
  localparam int EW   = YW + 1;
  localparam int KW   = 16;
  localparam int PW   = EW + KW;

  localparam logic [KW-1:0] K_LIGHT  = 16'd13030;
  localparam logic [KW-1:0] K_MEDIUM = 16'd3031;
  localparam logic [KW-1:0] K_HEAVY  = 16'd2507;

  localparam logic [YW-1:0] Y_MAX = {1'b0, {(YW-1){1'b1}}};
  localparam logic [YW-1:0] Y_MIN = {1'b1, {(YW-1){1'b0}}};

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    LIGHT  = 2'b01,
    MEDIUM = 2'b10,
    HEAVY  = 2'b11
  } lpf_sel_t;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    RD,
    MUL,
    WR,
    DONE
  } sched_state_t;

  function automatic logic [KW-1:0] lpf_coef(input lpf_sel_t sel);
    logic [KW-1:0] k;
    case (sel)
      LIGHT:   k = K_LIGHT;
      MEDIUM:  k = K_MEDIUM;
      HEAVY:   k = K_HEAVY;
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/tp_lpf_mac.sv
// One-pole low-pass update y' = sat(y + ((x<<8 - y) * k) >>> 16).
// The product is registered; shift, add and saturate follow combinationally.
module tp_lpf_mac
  import tp_snd_pkg::*;
(
  input  logic                 clk_49m,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 bypass,
  input  logic signed [XW-1:0] x,
  input  logic signed [YW-1:0] y,
  input  logic [KW-1:0]        k,
  output logic signed [YW-1:0] y_new
);

  logic signed [YW-1:0] x_sh;
  logic signed [EW-1:0] err;
  logic signed [PW-1:0] err_ext;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] prod_next;

  logic signed [PW-1:0] prod_reg;
  logic signed [YW-1:0] y_hold_reg;
  logic signed [YW-1:0] x_sh_reg;
  logic                 bypass_reg;

  logic signed [EW-1:0] delta;
  logic signed [EW:0]   sum;
  logic signed [YW-1:0] y_sat;

  assign x_sh      = {x, {FRAC{1'b0}}};
  assign err       = {x_sh[YW-1], x_sh} - {y[YW-1], y};
  assign err_ext   = {{(PW-EW){err[EW-1]}}, err};
  assign k_ext     = {{(PW-KW){1'b0}}, k};
  assign prod_next = err_ext * k_ext;

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      prod_reg   <= '0;
      y_hold_reg <= '0;
      x_sh_reg   <= '0;
      bypass_reg <= 1'b0;
    end else if (en) begin
      prod_reg   <= prod_next;
      y_hold_reg <= y;
      x_sh_reg   <= x_sh;
      bypass_reg <= bypass;
    end
  end

  // Taking the upper bits of the product is an arithmetic shift right by 16.
  assign delta = prod_reg[PW-1:KW];
  assign sum   = {y_hold_reg[YW-1], y_hold_reg[YW-1], y_hold_reg} + {delta[EW-1], delta};

  always_comb begin
    y_sat = sum[YW-1:0];
    if (sum[EW:YW-1] != {3{sum[EW]}}) begin
      y_sat = sum[EW] ? Y_MIN : Y_MAX;
    end
  end

  assign y_new = bypass_reg ? x_sh_reg : y_sat;

endmodule

// File: rtl/tp_lpf_scheduler.sv
// Six-channel AY low-pass filter sharing one multiplier: each accepted sample
// walks RD/MUL/WR per channel and publishes all outputs together in DONE.
module tp_lpf_scheduler
  import tp_snd_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk_49m,
  input  logic           reset,
  input  logic           sample_en,
  input  logic [6*W-1:0] ch_in,
  input  logic           sel_we,
  input  logic [11:0]    sel_addr,
  output logic [6*W-1:0] ch_out,
  output logic           out_valid,
  output logic           busy,
  output logic           overrun
);

  sched_state_t state_reg, state_next;
  logic [2:0]   ch_reg, ch_next;

  logic [2*NCH-1:0] sel_live_reg;
  logic [2*NCH-1:0] sel_dec;
  logic             accept;
  logic             last_wr;
  logic             out_valid_reg;
  logic             overrun_reg;

  logic [NCH-1:0][YW-1:0] y_vec;
  logic [NCH-1:0][W-1:0]  x_vec;
  logic [NCH-1:0][1:0]    sel_vec;

  logic signed [W-1:0]  x_op_reg;
  logic signed [YW-1:0] y_op_reg;
  logic [KW-1:0]        k_op_reg;
  logic                 byp_op_reg;
  logic signed [YW-1:0] y_new;

  // Per-channel code is {first bit, second bit}; ch0 lives in sel_dec[1:0].
  assign sel_dec = {sel_addr[4],  sel_addr[5],  sel_addr[2], sel_addr[3],
                    sel_addr[0],  sel_addr[1],  sel_addr[10], sel_addr[11],
                    sel_addr[8],  sel_addr[9],  sel_addr[6], sel_addr[7]};

  // The shadow copy is taken on the accepting edge, so a select written in
  // the same cycle as sample_en only applies to the following sample.
  assign accept  = (state_reg == IDLE) && sample_en;
  assign last_wr = (state_reg == WR) && (ch_reg == 3'(NCH-1));

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    case (state_reg)
      IDLE: if (sample_en) state_next = SNAP;
      SNAP: begin
        state_next = RD;
        ch_next    = '0;
      end
      RD:  state_next = MUL;
      MUL: state_next = WR;
      WR: begin
        if (ch_reg == 3'(NCH-1)) begin
          state_next = DONE;
        end else begin
          state_next = RD;
          ch_next    = ch_reg + 3'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      sel_live_reg  <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (sel_we) sel_live_reg <= sel_dec;
      out_valid_reg <= last_wr;
      if (sample_en && (state_reg != IDLE)) overrun_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      x_op_reg   <= '0;
      y_op_reg   <= '0;
      k_op_reg   <= '0;
      byp_op_reg <= 1'b0;
    end else if (state_reg == RD) begin
      x_op_reg   <= x_vec[ch_reg];
      y_op_reg   <= y_vec[ch_reg];
      k_op_reg   <= lpf_coef(lpf_sel_t'(sel_vec[ch_reg]));
      byp_op_reg <= (sel_vec[ch_reg] == BYPASS);
    end
  end

  tp_lpf_mac u_mac (
    .clk_49m (clk_49m),
    .reset   (reset),
    .en      (state_reg == MUL),
    .bypass  (byp_op_reg),
    .x       (x_op_reg),
    .y       (y_op_reg),
    .k       (k_op_reg),
    .y_new   (y_new)
  );

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic signed [YW-1:0] y_reg;
    logic signed [W-1:0]  x_shadow_reg;
    logic signed [W-1:0]  ch_out_reg;
    lpf_sel_t             sel_shadow_reg;
    logic                 wr_hit;

    assign wr_hit = (state_reg == WR) && (ch_reg == 3'(gi));

    always_ff @(posedge clk_49m or posedge reset) begin
      if (reset) begin
        y_reg          <= '0;
        x_shadow_reg   <= '0;
        ch_out_reg     <= '0;
        sel_shadow_reg <= BYPASS;
      end else begin
        if (accept) begin
          x_shadow_reg   <= ch_in[gi*W +: W];
          sel_shadow_reg <= lpf_sel_t'(sel_live_reg[2*gi +: 2]);
        end
        if (wr_hit) y_reg <= y_new;
        // The last channel is written on this same edge, so take its fresh value.
        if (last_wr) ch_out_reg <= wr_hit ? y_new[YW-1:FRAC] : y_reg[YW-1:FRAC];
      end
    end

    assign y_vec[gi]          = y_reg;
    assign x_vec[gi]          = x_shadow_reg;
    assign sel_vec[gi]        = sel_shadow_reg;
    assign ch_out[gi*W +: W]  = ch_out_reg;
  end

  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_tp_lpf_scheduler.sv
// Bench for tp_lpf_scheduler: a cycle-timed arithmetic model of the filter
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_tp_lpf_scheduler;

  logic        clk_49m = 1'b0;
  logic        reset;
  logic        sample_en;
  logic [95:0] ch_in;
  logic        sel_we;
  logic [11:0] sel_addr;
  logic [95:0] ch_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  tp_lpf_scheduler #(.W(16)) dut (
    .clk_49m   (clk_49m),
    .reset     (reset),
    .sample_en (sample_en),
    .ch_in     (ch_in),
    .sel_we    (sel_we),
    .sel_addr  (sel_addr),
    .ch_out    (ch_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #10 clk_49m = ~clk_49m;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     msb_idx[6] = '{6, 8, 10, 0, 2, 4};
  int     coef[4]    = '{0, 13030, 3031, 2507};
  longint my[6];
  longint pend[6];
  longint mout[6];
  int     msel[6];
  int     rem       = 0;
  bit     exp_busy  = 1'b0;
  bit     exp_valid = 1'b0;
  bit     exp_ovr   = 1'b0;

  initial begin
    for (int n = 0; n < 6; n++) begin
      my[n] = 0; pend[n] = 0; mout[n] = 0; msel[n] = 0;
    end
  end

  function automatic longint filt(input longint y, input longint x, input int s);
    longint e, p, yn;
    if (s == 0) return x * 256;
    e  = x * 256 - y;
    p  = e * coef[s];
    yn = y + (p >>> 16);
    if (yn > 8388607)  yn = 8388607;
    if (yn < -8388608) yn = -8388608;
    return yn;
  endfunction

  always @(posedge clk_49m) begin
    if (reset) begin
      for (int n = 0; n < 6; n++) begin
        my[n] = 0; mout[n] = 0; msel[n] = 0;
      end
      rem = 0; exp_busy = 0; exp_valid = 0; exp_ovr = 0;
    end else begin
      bit acc;
      acc = 1'b0;
      if (sample_en) begin
        if (exp_busy) exp_ovr = 1'b1;
        else          acc = 1'b1;
      end
      if (acc) begin
        for (int n = 0; n < 6; n++) begin
          my[n]   = filt(my[n], longint'($signed(ch_in[n*16 +: 16])), msel[n]);
          pend[n] = my[n] >>> 8;
        end
      end
      if (sel_we) begin
        for (int n = 0; n < 6; n++)
          msel[n] = 2 * int'(sel_addr[msb_idx[n]]) + int'(sel_addr[msb_idx[n] + 1]);
      end
      if (rem > 0) rem--;
      if (acc) rem = 20;
      exp_busy  = (rem > 0);
      exp_valid = (rem == 1);
      if (exp_valid) begin
        for (int n = 0; n < 6; n++) mout[n] = pend[n];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_49m) begin
    chk("out_valid", out_valid, exp_valid);
    chk("busy", busy, exp_busy);
    chk("overrun", overrun, exp_ovr);
    for (int n = 0; n < 6; n++)
      chk($sformatf("ch_out%0d", n), $signed(ch_out[n*16 +: 16]), mout[n]);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk_49m);
    #2;
  endtask

  task automatic set_ch(input int n, input int v);
    ch_in[n*16 +: 16] = 16'(v);
  endtask

  function automatic int out_ch(input int n);
    return int'($signed(ch_out[n*16 +: 16]));
  endfunction

  task automatic write_sel(input logic [11:0] a);
    sel_we = 1'b1; sel_addr = a;
    tick();
    sel_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Returns the cycle offset of out_valid relative to the sample_en cycle.
  task automatic pulse_sample(output int lat);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0; sel_we = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    tick();
  endtask

  initial begin
    int lat, prev, cur;
    reset = 1'b1; sample_en = 1'b0; sel_we = 1'b0; sel_addr = '0; ch_in = '0;
    repeat (3) tick();
    chk("rst_ch_out_any", |ch_out, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Bypass timing
    set_ch(0, 1000);
    pulse_sample(lat);
    chk("byp_latency", lat, 20);
    chk("byp_ch0", out_ch(0), 1000);

    // Light step response
    do_reset();
    write_sel(12'h080);
    set_ch(0, 16384);
    pulse_sample(lat);
    chk("light_first", out_ch(0), 3257);
    for (int i = 0; i < 80; i++) begin
      prev = out_ch(0);
      pulse_sample(lat);
      cur = out_ch(0);
      chk("light_mono", cur >= prev, 1);
      chk("light_bound", cur <= 16384, 1);
    end
    chk("light_settled", out_ch(0) >= 16383, 1);

    // Overrun
    do_reset();
    sample_en = 1'b1; tick(); sample_en = 1'b0;
    repeat (6) tick();
    sample_en = 1'b1; tick(); sample_en = 1'b0;
    chk("ovr_set", overrun, 1);
    repeat (17) tick();
    pulse_sample(lat);
    chk("ovr_next_latency", lat, 20);
    chk("ovr_sticky", overrun, 1);

    // Select written together with sample_en
    do_reset();
    set_ch(5, 5000);
    sel_we = 1'b1; sel_addr = 12'h030;
    pulse_sample(lat);
    chk("sel_same_cycle_bypass", out_ch(5), 5000);
    set_ch(5, -3000);
    pulse_sample(lat);
    chk("sel_next_heavy", out_ch(5), 4693);

    // Reset mid-sample
    do_reset();
    write_sel(12'h080);
    set_ch(0, 16384);
    pulse_sample(lat);
    chk("rstmid_pre", out_ch(0), 3257);
    sample_en = 1'b1; tick(); sample_en = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    #1;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ch_out_any", |ch_out, 0);
    tick();
    reset = 1'b0;
    repeat (25) tick();
    write_sel(12'h080);
    pulse_sample(lat);
    chk("rstmid_restart", out_ch(0), 3257);

    // Heavy filter on ch3 driven full-scale alternating
    do_reset();
    write_sel(12'h003);
    for (int i = 0; i < 2000; i++) begin
      ch_in = {$urandom, $urandom, $urandom};
      set_ch(3, (i % 2 == 0) ? 32767 : -32768);
      sample_en = 1'b1; tick(); sample_en = 1'b0;
      repeat (20) tick();
    end

    // Random traffic: samples, overruns, select writes, data
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      sample_en = ($urandom_range(0, 14) == 0);
      sel_we    = ($urandom_range(0, 9) == 0);
      sel_addr  = 12'($urandom);
      ch_in     = {$urandom, $urandom, $urandom};
      tick();
    end
    sample_en = 1'b0; sel_we = 1'b0;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
